// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MAR/MBR holder and single-port memory handshake for the 8-bit CPU
// Outputs are decoded from registered state only; mem_ack never reaches mem_req combinationally.
module mem_access_unit #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15,
   parameter int TO_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       control_signal,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic [DATA_W-1:0] pc_data,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [DATA_W-1:0] data_to_pc,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic              busy,
   output logic              done,
   output logic              timeout_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [DATA_W-1:0] mbr_q, mbr_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic              we_q, we_d;
   logic              terr_q, terr_d;
   logic              terr_set;
   logic [ADDR_W-1:0] mbr_addr;

   logic ld_mar, ld_mbr, rd_start, wr_start, clr_terr, ld_ind;
   logic unused_ctl;

   assign ld_mar   = control_signal[4];
   assign ld_mbr   = control_signal[5];
   assign rd_start = control_signal[6];
   assign wr_start = control_signal[7];
   assign ld_ind   = control_signal[8];
   assign clr_terr = control_signal[9];

   // Bits 1-3 and 20 drive the program counter; the rest are spare.
   assign unused_ctl = ^{control_signal[31:10], control_signal[3:0]};

   generate
      if (DATA_W >= ADDR_W) begin : g_mbr_trunc
         assign mbr_addr = mbr_q[ADDR_W-1:0];
      end else begin : g_mbr_ext
         assign mbr_addr = {{(ADDR_W-DATA_W){1'b0}}, mbr_q};
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      mar_d    = mar_q;
      mbr_d    = mbr_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      terr_set = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Loads land at the same edge as a start, so the transaction sees the new values.
            if (ld_ind) begin
               mar_d = mbr_addr;
            end else if (ld_mar) begin
               mar_d = pc_addr;
            end
            if (ld_mbr) begin
               mbr_d = pc_data;
            end
            if (rd_start || wr_start) begin
               state_d = S_REQ;
               cnt_d   = '0;
               we_d    = wr_start & ~rd_start;
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               state_d = S_DONE;
               if (!we_q) begin
                  mbr_d = mem_rdata;
               end
            end else if (cnt_q == TO_LAST) begin
               state_d  = S_IDLE;
               terr_set = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A timeout on the same edge as a clear request keeps the flag set.
      if (terr_set) begin
         terr_d = 1'b1;
      end else if (clr_terr) begin
         terr_d = 1'b0;
      end else begin
         terr_d = terr_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         mar_q   <= '0;
         mbr_q   <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mar_q   <= mar_d;
         mbr_q   <= mbr_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         terr_q  <= terr_d;
      end
   end

   assign data_to_pc  = mbr_q;
   assign mem_wdata   = mbr_q;
   assign mem_addr    = mar_q;
   assign mem_req     = (state_q == S_REQ);
   assign mem_we      = (state_q == S_REQ) & we_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign timeout_err = terr_q;

endmodule
